// File: rtl/fakeram_pkg.sv
// Shared constants and request payload for the fakeram_64x22 macro and its controller.
package fakeram_pkg;

    localparam int unsigned BITS       = 22;
    localparam int unsigned WORD_DEPTH = 64;
    localparam int unsigned ADDR_WIDTH = 6;
    localparam int unsigned RSP_DEPTH  = 3;
    localparam int unsigned CNT_W      = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [BITS-1:0]       wdata;
    } req_t;

endpackage

// File: rtl/fakeram_64x22_req_ctrl_if.sv
// Client-side request/response handshake bundle for the fakeram_64x22 controller.
interface fakeram_64x22_req_ctrl_if;
    import fakeram_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [BITS-1:0]       req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [BITS-1:0]       rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/fakeram_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; rdata shows the head entry.
module fakeram_rsp_fifo
    import fakeram_pkg::*;
#(
    parameter int unsigned DEPTH = RSP_DEPTH,
    parameter int unsigned W     = BITS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    // Storage needs no reset; only entries below count are ever presented.
    always_ff @(posedge clk) begin
        if (push && !reset) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

    a_no_push_full: assert property (@(posedge clk) disable iff (reset)
        !(push && count == CW'(DEPTH)));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (reset)
        !(pop && count == '0));

endmodule

// File: rtl/fakeram_64x22_req_ctrl.sv
// Request controller for fakeram_64x22: credit-gated issue to the macro, in-order read responses.
module fakeram_64x22_req_ctrl
    import fakeram_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    fakeram_64x22_req_ctrl_if.slave bus,
    output logic                  ce_in,
    output logic                  we_in,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic [BITS-1:0]       wd_in,
    input  logic [BITS-1:0]       rd_out
);

    localparam int unsigned SUM_W = CNT_W + 1;

    logic [CNT_W-1:0] fifo_count;
    logic             rd_inflight;
    logic             fire;
    logic             pop;
    req_t             req;

    assign req = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};

    // Credits count queued responses plus the read whose data lands next cycle.
    assign bus.req_ready = !reset &&
        ((SUM_W'(fifo_count) + SUM_W'(rd_inflight)) < SUM_W'(RSP_DEPTH));
    assign fire = bus.req_valid && bus.req_ready;

    // Macro pins are forced to zero whenever nothing is issued.
    always_comb begin
        ce_in   = 1'b0;
        we_in   = 1'b0;
        addr_in = '0;
        wd_in   = '0;
        if (fire) begin
            ce_in   = 1'b1;
            we_in   = req.we;
            addr_in = req.addr;
            wd_in   = req.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) rd_inflight <= 1'b0;
        else       rd_inflight <= fire && !req.we;
    end

    assign bus.rsp_valid = !reset && (fifo_count != '0);
    assign pop           = bus.rsp_valid && bus.rsp_ready;

    fakeram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .W     (BITS)
    ) u_rsp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rd_inflight),
        .pop   (pop),
        .wdata (rd_out),
        .rdata (bus.rsp_rdata),
        .count (fifo_count)
    );

endmodule
